// File: rtl/image_stream_tx.sv
// Output end of the filter pipeline: retransmits an unthrottled valid/pixel stream as a
// ready/valid stream with start-of-frame (m_tuser) and end-of-line (m_tlast) sideband.
// A show-ahead sync FIFO absorbs downstream stalls. On overflow the rest of the frame is
// dropped and the stream resynchronises at the next frame start.
module image_stream_tx #(
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned CNT_W      = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      img_width,
  input  logic [9:0]       img_height,
  input  logic             valid_i,
  input  logic [23:0]      img_data_i,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [23:0]      m_tdata,
  output logic             m_tuser,
  output logic             m_tlast,
  output logic             overflow,
  output logic             frame_done,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int unsigned AW = CNT_W - 1;

  typedef enum logic [0:0] {StStream, StDrop} state_e;

  state_e           state_q, state_d;
  logic [10:0]      x_q, x_d, w_q, w_d, w_eff;
  logic [9:0]       y_q, y_d, h_q, h_d, h_eff;
  logic [CNT_W-1:0] count_q, count_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;
  logic             frame_done_q, frame_done_d;
  logic [26:0]      mem_q [FIFO_DEPTH];

  logic             first, sof, eol, eof, full, wr_en, pop;
  logic [26:0]      wr_word, head;

  // Tag the incoming pixel from the pre-increment position; the frame's first pixel uses
  // the live geometry since that is the value being latched on the same cycle.
  always_comb begin
    first   = (x_q == 11'd0) && (y_q == 10'd0);
    w_eff   = first ? img_width  : w_q;
    h_eff   = first ? img_height : h_q;
    sof     = first;
    eol     = (x_q == w_eff - 11'd1);
    eof     = eol && (y_q == h_eff - 10'd1);
    wr_word = {eof, eol, sof, img_data_i};
  end

  // Position counters advance on every input pixel, stored or dropped.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    w_d = w_q;
    h_d = h_q;
    if (valid_i) begin
      if (first) begin
        w_d = img_width;
        h_d = img_height;
      end
      if (eol) begin
        x_d = 11'd0;
        y_d = (y_q == h_eff - 10'd1) ? 10'd0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 11'd1;
      end
    end
  end

  // Stream/drop FSM; fullness uses the registered count only, so a same-cycle pop
  // never makes room for an incoming pixel.
  always_comb begin
    state_d    = state_q;
    wr_en      = 1'b0;
    overflow_d = overflow_q;
    full       = (count_q == CNT_W'(FIFO_DEPTH));
    if (valid_i) begin
      unique case (state_q)
        StStream: begin
          if (full) begin
            state_d    = StDrop;
            overflow_d = 1'b1;
          end else begin
            wr_en = 1'b1;
          end
        end
        StDrop: begin
          if (sof) begin
            if (full) begin
              overflow_d = 1'b1;
            end else begin
              wr_en   = 1'b1;
              state_d = StStream;
            end
          end
        end
        default: state_d = StStream;
      endcase
    end
  end

  // Show-ahead read side, pointer/count bookkeeping and the end-of-frame pulse.
  always_comb begin
    head         = mem_q[rd_ptr_q];
    m_tvalid     = (count_q != '0);
    m_tdata      = m_tvalid ? head[23:0] : 24'd0;
    m_tuser      = m_tvalid & head[24];
    m_tlast      = m_tvalid & head[25];
    pop          = m_tvalid && m_tready;
    rd_ptr_d     = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d     = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    count_d      = count_q + CNT_W'(wr_en) - CNT_W'(pop);
    frame_done_d = pop && head[26];
    overflow     = overflow_q;
    frame_done   = frame_done_q;
    fifo_count   = count_q;
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StStream;
      x_q          <= '0;
      y_q          <= '0;
      w_q          <= '0;
      h_q          <= '0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      w_q          <= w_d;
      h_q          <= h_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  // FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_word;
    end
  end

endmodule

// File: tb/tb_image_stream_tx.sv
// Self-checking bench for image_stream_tx: a queue scoreboard receives the expected tagged
// word whenever a pixel is driven and is popped whenever the DUT hands a word out.
module tb_image_stream_tx;

  // Small FIFO so overflow and full-boundary cases are reachable quickly.
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [10:0]   img_width = 11'd4;
  logic [9:0]    img_height = 10'd2;
  logic          valid_i = 1'b0;
  logic [23:0]   img_data_i = 24'd0;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [23:0]   m_tdata;
  logic          m_tuser;
  logic          m_tlast;
  logic          overflow;
  logic          frame_done;
  logic [CW-1:0] fifo_count;

  always #5 clk = ~clk;

  image_stream_tx #(
    .FIFO_DEPTH(DEPTH),
    .CNT_W     (CW)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .img_width (img_width),
    .img_height(img_height),
    .valid_i   (valid_i),
    .img_data_i(img_data_i),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tdata   (m_tdata),
    .m_tuser   (m_tuser),
    .m_tlast   (m_tlast),
    .overflow  (overflow),
    .frame_done(frame_done),
    .fifo_count(fifo_count)
  );

  int          n_total = 0;
  int          n_bad   = 0;
  logic [26:0] sb_q[$];
  int          mx, my, mw, mh;
  bit          m_drop, m_ovf, m_fd;
  int          fd_seen;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    sb_q.delete();
    mx = 0; my = 0; mw = 0; mh = 0;
    m_drop = 1'b0; m_ovf = 1'b0; m_fd = 1'b0;
  endtask

  task automatic check_outputs();
    logic [26:0] hd;
    hd = (sb_q.size() != 0) ? sb_q[0] : 27'd0;
    check_eq("tvalid", 32'(m_tvalid), 32'(sb_q.size() != 0));
    check_eq("count", 32'(fifo_count), 32'(sb_q.size()));
    check_eq("tdata", 32'(m_tdata), 32'(hd[23:0]));
    check_eq("tuser", 32'(m_tuser), 32'(hd[24]));
    check_eq("tlast", 32'(m_tlast), 32'(hd[25]));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
    check_eq("frame_done", 32'(frame_done), 32'(m_fd));
    if (frame_done) fd_seen++;
  endtask

  // One clock cycle: check the DUT against the model, drive new inputs, advance the model.
  task automatic step(input bit v, input logic [23:0] d, input bit rdy);
    bit          first, sof, eol, eof, full, pop;
    int          we, he;
    logic [26:0] w;
    @(negedge clk);
    check_outputs();
    valid_i    = v;
    img_data_i = d;
    m_tready   = rdy;
    full = (sb_q.size() == DEPTH);
    pop  = (sb_q.size() != 0) && rdy;
    m_fd = 1'b0;
    if (pop) begin
      w    = sb_q.pop_front();
      m_fd = w[26];
    end
    if (v) begin
      first = (mx == 0) && (my == 0);
      we    = first ? int'(img_width)  : mw;
      he    = first ? int'(img_height) : mh;
      if (first) begin
        mw = we;
        mh = he;
      end
      sof = first;
      eol = (mx == we - 1);
      eof = eol && (my == he - 1);
      w   = {eof, eol, sof, d};
      if (m_drop) begin
        if (sof && !full) begin
          m_drop = 1'b0;
          sb_q.push_back(w);
        end else if (full) begin
          m_ovf = 1'b1;
        end
      end else if (full) begin
        m_drop = 1'b1;
        m_ovf  = 1'b1;
      end else begin
        sb_q.push_back(w);
      end
      if (eol) begin
        mx = 0;
        my = (my == he - 1) ? 0 : my + 1;
      end else begin
        mx++;
      end
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 24'd0, 1'b1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_tvalid"}, 32'(m_tvalid), 32'd0);
    check_eq({pfx, "_tdata"}, 32'(m_tdata), 32'd0);
    check_eq({pfx, "_tuser"}, 32'(m_tuser), 32'd0);
    check_eq({pfx, "_tlast"}, 32'(m_tlast), 32'd0);
    check_eq({pfx, "_overflow"}, 32'(overflow), 32'd0);
    check_eq({pfx, "_frame_done"}, 32'(frame_done), 32'd0);
    check_eq({pfx, "_count"}, 32'(fifo_count), 32'd0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset    = 1'b1;
    valid_i  = 1'b0;
    m_tready = 1'b0;
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    model_clear();
    fd_seen = 0;

    // Pass-through: one frame of 4x2, always ready.
    reset_dut();
    img_width = 11'd4; img_height = 10'd2; fd_seen = 0;
    for (int i = 1; i <= 8; i++) step(1'b1, 24'(i), 1'b1);
    drain(3);
    check_eq("t1_frame_done_pulses", 32'(fd_seen), 32'd1);

    // Backpressure without loss: stall to one short of full, then release.
    reset_dut();
    img_width = 11'd4; img_height = 10'd2;
    for (int i = 1; i <= 7; i++) step(1'b1, 24'(16'hA000 + i), 1'b0);
    step(1'b1, 24'hA008, 1'b1);
    drain(10);
    check_eq("t2_no_overflow", 32'(overflow), 32'd0);

    // Overflow and resync: 4x4 frame into an 8-deep stalled FIFO, then a clean frame.
    reset_dut();
    img_width = 11'd4; img_height = 10'd4; fd_seen = 0;
    for (int i = 1; i <= 16; i++) step(1'b1, 24'(16'hB000 + i), 1'b0);
    drain(10);
    for (int i = 1; i <= 16; i++) step(1'b1, 24'(16'hC000 + i), 1'b1);
    drain(4);
    check_eq("t3_overflow_sticky", 32'(overflow), 32'd1);
    check_eq("t3_frame_done_pulses", 32'(fd_seen), 32'd1);

    // Boundary at full: write and pop on the same edge; write must be dropped.
    reset_dut();
    img_width = 11'd4; img_height = 10'd4;
    for (int i = 1; i <= 8; i++) step(1'b1, 24'(16'hD000 + i), 1'b0);
    step(1'b1, 24'hD009, 1'b1);
    step(1'b1, 24'hD00A, 1'b1);
    check_eq("t4_count_after_full_pop", 32'(fifo_count), 32'(DEPTH - 1));
    drain(10);

    // Degenerate 1x1 geometry: every pixel is a whole frame.
    reset_dut();
    img_width = 11'd1; img_height = 10'd1; fd_seen = 0;
    for (int i = 1; i <= 3; i++) step(1'b1, 24'(16'hE000 + i), 1'b1);
    drain(3);
    check_eq("t5_frame_done_pulses", 32'(fd_seen), 32'd3);

    // Asynchronous reset mid-frame, away from any clock edge.
    reset_dut();
    img_width = 11'd8; img_height = 10'd8;
    for (int i = 1; i <= 20; i++) step(1'b1, 24'(16'hF000 + i), 1'b1);
    @(posedge clk);
    #2;
    check_eq("t6_tvalid_before_reset", 32'(m_tvalid), 32'd1);
    reset = 1'b1;
    #1;
    check_reset_outputs("t6_async");
    model_clear();
    @(negedge clk);
    reset   = 1'b0;
    valid_i = 1'b0;
    for (int i = 1; i <= 4; i++) step(1'b1, 24'(16'h7000 + i), 1'b1);
    drain(3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
